// File: rtl/usb_txn_ctrl.sv
// rtl/usb_txn_ctrl.sv - USB device transaction controller: token/data/handshake sequencing
//
// Sequences one USB device-side transaction at a time. An OUT token is followed
// by a DATAx packet that is acknowledged. An IN token is answered with either
// a DATAx payload or a NAK, and a payload is then acknowledged by the host.
// The controller keeps separate RX and TX data toggles and reports results to
// the AHB side through one-cycle status pulses.
//
// Ports:
//   clk                 system clock, rising edge
//   n_rst               asynchronous active-low reset
//   rx_packet[2:0]      decoded RX PID (1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 IDLE)
//   rx_data_ready       one-cycle strobe qualifying rx_packet
//   rx_error            RX CRC/bitstuff/EOP error (level)
//   tx_transfer_active  USB TX currently transmitting
//   tx_error            USB TX error (level)
//   tx_data_avail       a TX payload is loaded
//   buffer_occupancy    data buffer byte count
//   toggle_clr          pulse, returns both toggles to DATA0
//   tx_packet[2:0]      TX request (0 NONE, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK)
//   d_mode              high while the device drives the bus
//   flush               one-cycle pulse, clear data buffer
//   rx_done/tx_done/xfer_error  one-cycle status pulses
module usb_txn_ctrl #(
  parameter logic [7:0] TIMEOUT = 8'd100
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] rx_packet,
  input  logic       rx_data_ready,
  input  logic       rx_error,
  input  logic       tx_transfer_active,
  input  logic       tx_error,
  input  logic       tx_data_avail,
  input  logic [6:0] buffer_occupancy,
  input  logic       toggle_clr,
  output logic [2:0] tx_packet,
  output logic       d_mode,
  output logic       flush,
  output logic       rx_done,
  output logic       tx_done,
  output logic       xfer_error
);

  localparam logic [2:0] PID_OUT   = 3'd1;
  localparam logic [2:0] PID_IN    = 3'd2;
  localparam logic [2:0] PID_DATA0 = 3'd3;
  localparam logic [2:0] PID_DATA1 = 3'd4;
  localparam logic [2:0] PID_ACK   = 3'd5;

  localparam logic [2:0] TX_NONE  = 3'd0;
  localparam logic [2:0] TX_DATA0 = 3'd1;
  localparam logic [2:0] TX_DATA1 = 3'd2;
  localparam logic [2:0] TX_ACK   = 3'd3;
  localparam logic [2:0] TX_NAK   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_RX_WAIT     = 3'd1,
    ST_HS_SEND     = 3'd2,
    ST_TX_SEND     = 3'd3,
    ST_TX_WAIT_ACK = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       seen_active;
  logic       rx_toggle;
  logic       tx_toggle;

  // PID 0 is not a defined code and is ignored everywhere, so only 1..7
  // counts as a real packet for the "unexpected packet" error paths.
  logic strobe;
  logic valid_pid;
  logic is_data;
  logic data_match;
  logic timed_out;

  assign strobe     = rx_data_ready;
  assign valid_pid  = (rx_packet != 3'd0);
  assign is_data    = (rx_packet == PID_DATA0) || (rx_packet == PID_DATA1);
  assign data_match = ((rx_packet == PID_DATA0) && !rx_toggle) ||
                      ((rx_packet == PID_DATA1) &&  rx_toggle);
  assign timed_out  = (cnt == TIMEOUT - 8'd1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      seen_active <= 1'b0;
      rx_toggle   <= 1'b0;
      tx_toggle   <= 1'b0;
      tx_packet   <= TX_NONE;
      d_mode      <= 1'b0;
      flush       <= 1'b0;
      rx_done     <= 1'b0;
      tx_done     <= 1'b0;
      xfer_error  <= 1'b0;
    end else begin
      flush      <= 1'b0;
      rx_done    <= 1'b0;
      tx_done    <= 1'b0;
      xfer_error <= 1'b0;
      // Free-running in the waiting states; every transition below re-clears it.
      cnt <= (state == ST_IDLE) ? 8'd0 : cnt + 8'd1;

      case (state)
        ST_IDLE: begin
          seen_active <= 1'b0;
          if (strobe && rx_packet == PID_OUT) begin
            state <= ST_RX_WAIT;
            cnt   <= 8'd0;
          end else if (strobe && rx_packet == PID_IN) begin
            cnt    <= 8'd0;
            d_mode <= 1'b1;
            if (tx_data_avail && buffer_occupancy != 7'd0) begin
              state     <= ST_TX_SEND;
              tx_packet <= tx_toggle ? TX_DATA1 : TX_DATA0;
            end else begin
              state     <= ST_HS_SEND;
              tx_packet <= TX_NAK;
            end
          end
        end

        ST_RX_WAIT: begin
          // Error is tested first so a corrupted packet that is also strobed
          // never gets acknowledged.
          if (rx_error || (strobe && valid_pid && !is_data) ||
              (!(strobe && is_data) && timed_out)) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            flush      <= 1'b1;
            xfer_error <= 1'b1;
          end else if (strobe && is_data) begin
            state       <= ST_HS_SEND;
            cnt         <= 8'd0;
            seen_active <= 1'b0;
            tx_packet   <= TX_ACK;
            d_mode      <= 1'b1;
            if (data_match) begin
              rx_toggle <= ~rx_toggle;
              rx_done   <= 1'b1;
            end else begin
              // Host retried a packet already accepted: ack it again, drop the data.
              flush <= 1'b1;
            end
          end
        end

        ST_HS_SEND, ST_TX_SEND: begin
          if (tx_error || (!seen_active && !tx_transfer_active && timed_out)) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            tx_packet  <= TX_NONE;
            d_mode     <= 1'b0;
            xfer_error <= 1'b1;
          end else if (seen_active && !tx_transfer_active) begin
            // Transmission has started and finished.
            state       <= (state == ST_TX_SEND) ? ST_TX_WAIT_ACK : ST_IDLE;
            cnt         <= 8'd0;
            seen_active <= 1'b0;
            tx_packet   <= TX_NONE;
            d_mode      <= 1'b0;
          end else if (tx_transfer_active) begin
            seen_active <= 1'b1;
          end
        end

        ST_TX_WAIT_ACK: begin
          if (rx_error || (strobe && valid_pid && rx_packet != PID_ACK) ||
              (!(strobe && rx_packet == PID_ACK) && timed_out)) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            flush      <= 1'b1;
            xfer_error <= 1'b1;
          end else if (strobe && rx_packet == PID_ACK) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            tx_toggle <= ~tx_toggle;
            tx_done   <= 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          cnt       <= 8'd0;
          tx_packet <= TX_NONE;
          d_mode    <= 1'b0;
        end
      endcase

      // Placed last so it overrides any toggle update made this cycle.
      if (toggle_clr) begin
        rx_toggle <= 1'b0;
        tx_toggle <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// tb/tb_usb_txn_ctrl.sv - self-checking bench for usb_txn_ctrl with transaction-level toggle model
module tb_usb_txn_ctrl;

  localparam int TO = 100;

  logic       clk;
  logic       n_rst;
  logic [2:0] rx_packet;
  logic       rx_data_ready;
  logic       rx_error;
  logic       tx_transfer_active;
  logic       tx_error;
  logic       tx_data_avail;
  logic [6:0] buffer_occupancy;
  logic       toggle_clr;
  logic [2:0] tx_packet;
  logic       d_mode;
  logic       flush;
  logic       rx_done;
  logic       tx_done;
  logic       xfer_error;

  int errors = 0;
  int checks = 0;

  // Reference model: the two data toggles as seen by a USB host.
  logic m_rx = 1'b0;
  logic m_tx = 1'b0;

  usb_txn_ctrl dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .rx_packet          (rx_packet),
    .rx_data_ready      (rx_data_ready),
    .rx_error           (rx_error),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error),
    .tx_data_avail      (tx_data_avail),
    .buffer_occupancy   (buffer_occupancy),
    .toggle_clr         (toggle_clr),
    .tx_packet          (tx_packet),
    .d_mode             (d_mode),
    .flush              (flush),
    .rx_done            (rx_done),
    .tx_done            (tx_done),
    .xfer_error         (xfer_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rx(input logic [2:0] pid);
    rx_packet     = pid;
    rx_data_ready = 1'b1;
    step();
    rx_data_ready = 1'b0;
    rx_packet     = 3'd7;
  endtask

  // Plays the USB TX engine: idle, transmit for len cycles, then drop.
  task automatic run_tx(input logic [2:0] code, input int dly, input int len);
    step();
    chk("pulse_width", {flush, rx_done, tx_done, xfer_error}, 0);
    chk("hold_txp", tx_packet, code);
    repeat (dly) begin
      step();
      chk("hold_txp_dly", tx_packet, code);
    end
    tx_transfer_active = 1'b1;
    repeat (len) begin
      step();
      chk("hold_txp_act", tx_packet, code);
      chk("hold_dmode", d_mode, 1);
    end
    tx_transfer_active = 1'b0;
    step();
    chk("exit_txp_none", tx_packet, 0);
    chk("exit_dmode", d_mode, 0);
  endtask

  task automatic do_out(input logic [2:0] dpid);
    logic match;
    pulse_rx(3'd1);
    chk("out_txp", tx_packet, 0);
    chk("out_dmode", d_mode, 0);
    match = (dpid == 3'd3 && !m_rx) || (dpid == 3'd4 && m_rx);
    pulse_rx(dpid);
    chk("data_rx_done", rx_done, match);
    chk("data_flush", flush, !match);
    chk("data_txp_ack", tx_packet, 3);
    chk("data_dmode", d_mode, 1);
    chk("data_xerr", xfer_error, 0);
    if (match) m_rx = ~m_rx;
    run_tx(3'd3, $urandom_range(0, 3), $urandom_range(1, 4));
  endtask

  task automatic do_in(input logic avail, input logic [6:0] occ, input logic [2:0] resp);
    logic       has;
    logic [2:0] exp;
    tx_data_avail    = avail;
    buffer_occupancy = occ;
    has = avail && (occ != 0);
    exp = has ? (m_tx ? 3'd2 : 3'd1) : 3'd4;
    pulse_rx(3'd2);
    chk("in_txp", tx_packet, exp);
    chk("in_dmode", d_mode, 1);
    run_tx(exp, $urandom_range(0, 3), $urandom_range(1, 4));
    if (has) begin
      pulse_rx(resp);
      if (resp == 3'd5) begin
        chk("ack_tx_done", tx_done, 1);
        chk("ack_xerr", xfer_error, 0);
        chk("ack_flush", flush, 0);
        m_tx = ~m_tx;
      end else begin
        chk("nak_tx_done", tx_done, 0);
        chk("nak_xerr", xfer_error, 1);
        chk("nak_flush", flush, 1);
      end
      step();
      chk("resp_pulse_width", {flush, rx_done, tx_done, xfer_error}, 0);
    end
  endtask

  initial begin
    int n;
    n_rst              = 1'b0;
    rx_packet          = 3'd7;
    rx_data_ready      = 1'b0;
    rx_error           = 1'b0;
    tx_transfer_active = 1'b0;
    tx_error           = 1'b0;
    tx_data_avail      = 1'b0;
    buffer_occupancy   = 7'd0;
    toggle_clr         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txp", tx_packet, 0);
    chk("rst_dmode", d_mode, 0);
    chk("rst_pulses", {flush, rx_done, tx_done, xfer_error}, 0);
    n_rst = 1'b1;
    step();

    // OUT / DATA0 accepted, then the same DATA0 retried
    do_out(3'd3);
    do_out(3'd3);

    // IN with payload twice: DATA0 then DATA1; IN with empty buffer -> NAK
    do_in(1'b1, 7'd4, 3'd5);
    do_in(1'b1, 7'd4, 3'd5);
    do_in(1'b1, 7'd0, 3'd5);

    // OUT with no data: timeout after TO cycles in RX_WAIT
    pulse_rx(3'd1);
    n = 0;
    while (!xfer_error && n < 150) begin
      step();
      n++;
    end
    chk("rx_timeout_cycles", n, TO);
    chk("rx_timeout_flush", flush, 1);
    step();
    chk("rx_timeout_pulse_width", {flush, xfer_error}, 0);

    // NAK handshake that the TX engine never transmits
    tx_data_avail = 1'b0;
    pulse_rx(3'd2);
    n = 0;
    while (!xfer_error && n < 150) begin
      step();
      n++;
    end
    chk("hs_timeout_cycles", n, TO);
    chk("hs_timeout_flush", flush, 0);
    chk("hs_timeout_txp", tx_packet, 0);
    chk("hs_timeout_dmode", d_mode, 0);

    // rx_error together with a matching DATA strobe: error wins
    pulse_rx(3'd1);
    rx_error = 1'b1;
    pulse_rx(m_rx ? 3'd4 : 3'd3);
    rx_error = 1'b0;
    chk("rxerr_xerr", xfer_error, 1);
    chk("rxerr_flush", flush, 1);
    chk("rxerr_rx_done", rx_done, 0);
    chk("rxerr_dmode", d_mode, 0);

    // randomized transaction mix against the toggle model
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_out($urandom_range(0, 1) ? 3'd4 : 3'd3);
      else
        do_in($urandom_range(0, 1) ? 1'b1 : 1'b0,
              $urandom_range(0, 1) ? 7'($urandom_range(1, 127)) : 7'd0,
              $urandom_range(0, 2) != 0 ? 3'd5 : 3'd6);
    end

    // toggle_clr while waiting for data: DATA0 must then be accepted
    if (!m_rx) do_out(3'd3);
    pulse_rx(3'd1);
    toggle_clr = 1'b1;
    step();
    toggle_clr = 1'b0;
    m_rx = 1'b0;
    m_tx = 1'b0;
    pulse_rx(3'd3);
    chk("tclr_rx_done", rx_done, 1);
    chk("tclr_flush", flush, 0);
    m_rx = 1'b1;
    run_tx(3'd3, 1, 2);
    do_in(1'b1, 7'd9, 3'd5);

    // asynchronous reset in the middle of a DATA transmission
    tx_data_avail    = 1'b1;
    buffer_occupancy = 7'd4;
    pulse_rx(3'd2);
    chk("prerst_txp", tx_packet, m_tx ? 2 : 1);
    tx_transfer_active = 1'b1;
    step();
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_rst_txp", tx_packet, 0);
    chk("async_rst_dmode", d_mode, 0);
    tx_transfer_active = 1'b0;
    step();
    n_rst = 1'b1;
    m_rx = 1'b0;
    m_tx = 1'b0;
    step();
    do_in(1'b1, 7'd4, 3'd5);
    do_out(3'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_txn_ctrl.md
USB_TXN_CTRL -- requirements
Module: usb_txn_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd100, cycles allowed for a bus reply before abort.
REQ-002 SHALL have port clk  in  1  system clock, all flops rising-edge.
REQ-003 SHALL have port n_rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_packet  in  3  decoded RX PID: 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 IDLE; others ignored.
REQ-005 SHALL have port rx_data_ready  in  1  one-cycle strobe: rx_packet valid this cycle.
REQ-006 SHALL have port rx_error  in  1  RX CRC/bitstuff/EOP error, level.
REQ-007 SHALL have port tx_transfer_active  in  1  USB TX is transmitting.
REQ-008 SHALL have port tx_error  in  1  USB TX error, level.
REQ-009 SHALL have port tx_data_avail  in  1  AHB side has loaded a TX payload.
REQ-010 SHALL have port buffer_occupancy  in  7  data buffer byte count.
REQ-011 SHALL have port toggle_clr  in  1  pulse: reset both data toggles to DATA0.
REQ-012 SHALL have port tx_packet  out  3  TX request: 0 NONE, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK.
REQ-013 SHALL have port d_mode  out  1  1 while the device owns the bus (HS_SEND, TX_SEND).
REQ-014 SHALL have port flush  out  1  one-cycle pulse: clear data buffer.
REQ-015 SHALL have port rx_done, tx_done, xfer_error  out  1 each  one-cycle status pulses to AHB status.

Function
REQ-016 SHALL implement states IDLE, RX_WAIT, HS_SEND, TX_SEND, TX_WAIT_ACK; all outputs registered.
REQ-017 IDLE: strobe with OUT -> RX_WAIT; strobe with IN and tx_data_avail=1 and buffer_occupancy!=0 -> TX_SEND; strobe with IN otherwise -> HS_SEND with NAK; all other PIDs and rx_error ignored.
REQ-018 RX_WAIT: strobe with DATA0/DATA1 matching rx_toggle -> rx_toggle inverts, rx_done pulse, HS_SEND with ACK.
REQ-019 RX_WAIT: strobe with non-matching DATAx (retry duplicate) -> flush pulse, toggle unchanged, HS_SEND with ACK.
REQ-020 RX_WAIT: rx_error, any non-DATA strobe, or timeout -> flush pulse, xfer_error pulse, IDLE, no handshake sent.
REQ-021 HS_SEND/TX_SEND: tx_packet held at request code (TX_SEND: DATA0 if tx_toggle=0 else DATA1) for whole state; state exits after tx_transfer_active seen high then low.
REQ-022 HS_SEND exits to IDLE; TX_SEND exits to TX_WAIT_ACK; tx_packet returns to NONE the cycle after exit.
REQ-023 HS_SEND/TX_SEND: tx_error, or tx_transfer_active never high within TIMEOUT cycles -> xfer_error pulse, IDLE.
REQ-024 TX_WAIT_ACK: strobe with ACK -> tx_toggle inverts, tx_done pulse, IDLE.
REQ-025 TX_WAIT_ACK: NAK, other PID, rx_error, or timeout -> xfer_error pulse, flush pulse, toggle unchanged, IDLE.
REQ-026 Timeout counter 8-bit, cleared on every state entry, increments in RX_WAIT, HS_SEND, TX_SEND, TX_WAIT_ACK; timeout fires on the cycle count reaches TIMEOUT-1 with no qualifying event.
REQ-027 Same-cycle rx_error and rx_data_ready: error path wins.
REQ-028 toggle_clr honored in any state, effective next cycle, does not change state; same-cycle toggle update loses to toggle_clr.
REQ-029 Pulses (flush, rx_done, tx_done, xfer_error) last exactly one cycle, registered on the transition edge.

Reset
REQ-030 n_rst low SHALL force IDLE, tx_packet=0, d_mode=0, all pulses 0, both toggles 0, counter 0, seen-active flag 0, asynchronously, including mid-transfer.

Verification
REQ-031 OUT, DATA0 strobes, rx_toggle=0 -> rx_done pulse, tx_packet=3 (ACK), d_mode=1 until TX active falls; rx_toggle=1.
REQ-032 Repeat DATA0 after REQ-031 -> flush pulse, ACK sent, rx_done=0, rx_toggle stays 1.
REQ-033 IN with tx_data_avail=1, occupancy=4 -> tx_packet=1 (DATA0); host ACK -> tx_done pulse, next IN sends tx_packet=2.
REQ-034 IN with occupancy=0 -> tx_packet=4 (NAK), no toggle change.
REQ-035 OUT then no strobe for TIMEOUT=100 cycles -> xfer_error and flush pulses at cycle 99, IDLE.
REQ-036 n_rst low during TX_SEND -> tx_packet=0, d_mode=0 immediately; toggle_clr in RX_WAIT -> next DATA0 accepted.
